// File: rtl/race_pkg.sv
// Shared encodings and helpers for the LED racer game sequencer.
package race_pkg;
  localparam int MAX_PLAYERS = 4;
  localparam int PLAYER_ID_W = 2;

  typedef enum logic [1:0] {
    SCREEN_MENU      = 2'b00,
    SCREEN_GAME      = 2'b01,
    SCREEN_END       = 2'b10,
    SCREEN_COUNTDOWN = 2'b11
  } screen_e;

  function automatic logic [2:0] popcount(input logic [MAX_PLAYERS-1:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < MAX_PLAYERS; i++) c = c + {2'b0, m[i]};
    return c;
  endfunction
endpackage

// File: rtl/race_screen_controller_btn_rise_detect.sv
// Width-parameterised rising-edge detector; history is registered, rise is
// combinational so an edge is acted on in the same clock it arrives.
module btn_rise_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= level;
  end

  assign rise = level & ~prev;
endmodule

// File: rtl/race_screen_controller.sv
// Game sequencer: menu joins, start countdown, winner arbitration, end hold.
module race_screen_controller
  import race_pkg::*;
#(
  parameter int NUM_PLAYERS              = 4,
  parameter int COUNTDOWN_START          = 3,
  parameter int COUNTDOWN_STEP_CLK_COUNT = 1,
  parameter int MIN_PLAYERS              = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PLAYERS-1:0] player_btn,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] player_finished,
  input  logic                   trigger_reset_all,
  output logic [1:0]             current_screen,
  output logic [NUM_PLAYERS-1:0] active_players,
  output logic [2:0]             countdown_value,
  output logic                   game_enable,
  output logic [PLAYER_ID_W-1:0] winner_id,
  output logic                   winner_valid
);
  localparam int CNT_W = (COUNTDOWN_STEP_CLK_COUNT > 1) ? $clog2(COUNTDOWN_STEP_CLK_COUNT) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(COUNTDOWN_STEP_CLK_COUNT - 1);
  localparam logic [2:0]       CD_START  = 3'(COUNTDOWN_START);

  screen_e                  state;
  logic [CNT_W-1:0]         step_cnt;
  logic [NUM_PLAYERS-1:0]   player_rise;
  logic                     start_rise;
  logic [NUM_PLAYERS-1:0]   hit;
  logic [PLAYER_ID_W-1:0]   win_idx;
  logic                     start_ok;

  btn_rise_detect #(.W(NUM_PLAYERS)) u_player_rise (
    .clk(clk), .reset(reset), .level(player_btn), .rise(player_rise)
  );

  btn_rise_detect #(.W(1)) u_start_rise (
    .clk(clk), .reset(reset), .level(start_btn), .rise(start_rise)
  );

  // Start qualification deliberately looks at the registered (pre-join) mask.
  assign start_ok = int'(popcount(MAX_PLAYERS'(active_players))) >= MIN_PLAYERS;
  assign hit      = player_finished & active_players;

  // Lowest set index wins; scan downward so the last assignment is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (hit[i]) win_idx = PLAYER_ID_W'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= SCREEN_MENU;
      step_cnt        <= '0;
      active_players  <= '0;
      countdown_value <= '0;
      game_enable     <= 1'b0;
      winner_id       <= '0;
      winner_valid    <= 1'b0;
    end else if (trigger_reset_all) begin
      state           <= SCREEN_MENU;
      step_cnt        <= '0;
      active_players  <= '0;
      countdown_value <= '0;
      game_enable     <= 1'b0;
      winner_valid    <= 1'b0;
    end else begin
      case (state)
        SCREEN_MENU: begin
          active_players <= active_players | player_rise;
          if (start_rise && start_ok) begin
            state           <= SCREEN_COUNTDOWN;
            countdown_value <= CD_START;
            step_cnt        <= '0;
          end
        end
        SCREEN_COUNTDOWN: begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            if (countdown_value == 3'd1) begin
              state           <= SCREEN_GAME;
              countdown_value <= '0;
              game_enable     <= 1'b1;
            end else begin
              countdown_value <= countdown_value - 3'd1;
            end
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        SCREEN_GAME: begin
          if (|hit) begin
            state        <= SCREEN_END;
            winner_id    <= win_idx;
            winner_valid <= 1'b1;
            game_enable  <= 1'b0;
          end
        end
        SCREEN_END: ;
        default: state <= SCREEN_MENU;
      endcase
    end
  end

  assign current_screen = state;
endmodule

// File: tb/tb_race_screen_controller.sv
// Scoreboard bench: expected outputs are queued as stimulus is driven and
// compared once the clock edge that should produce them has passed.
module tb_race_screen_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] player_btn;
  logic       start_btn;
  logic [3:0] player_finished;
  logic       trigger_reset_all;
  logic [1:0] current_screen;
  logic [3:0] active_players;
  logic [2:0] countdown_value;
  logic       game_enable;
  logic [1:0] winner_id;
  logic       winner_valid;

  typedef struct packed {
    logic [1:0] scr;
    logic [3:0] act;
    logic [2:0] cd;
    logic       ge;
    logic [1:0] wid;
    logic       wv;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  race_screen_controller #(
    .NUM_PLAYERS(4), .COUNTDOWN_START(3), .COUNTDOWN_STEP_CLK_COUNT(4), .MIN_PLAYERS(1)
  ) dut (
    .clk(clk), .reset(reset), .player_btn(player_btn), .start_btn(start_btn),
    .player_finished(player_finished), .trigger_reset_all(trigger_reset_all),
    .current_screen(current_screen), .active_players(active_players),
    .countdown_value(countdown_value), .game_enable(game_enable),
    .winner_id(winner_id), .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @step %0d: got %0h expected %0h", tag, n_step, obs, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t x;
    x = sb.pop_front();
    chk("screen",        8'(current_screen),  8'(x.scr));
    chk("active_players", 8'(active_players), 8'(x.act));
    chk("countdown",     8'(countdown_value), 8'(x.cd));
    chk("game_enable",   8'(game_enable),     8'(x.ge));
    chk("winner_id",     8'(winner_id),       8'(x.wid));
    chk("winner_valid",  8'(winner_valid),    8'(x.wv));
    n_step++;
  endtask

  // Queue the current expectation, let one edge happen, then compare.
  task automatic tick();
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic enter_countdown();
    start_btn = 1'b1;
    e.scr = 2'b11; e.cd = 3'd3;
    tick();
    start_btn = 1'b0;
  endtask

  // Runs from just after countdown entry; each digit held 4 clocks.
  task automatic run_countdown(input int upto);
    for (int k = 1; k <= upto; k++) begin
      if (k == 4)  e.cd = 3'd2;
      if (k == 8)  e.cd = 3'd1;
      if (k == 12) begin e.scr = 2'b01; e.cd = 3'd0; e.ge = 1'b1; end
      if (k == 2) player_btn = 4'b0001;
      if (k == 3) player_btn = 4'b0000;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; player_btn = '0; start_btn = 1'b0;
    player_finished = '0; trigger_reset_all = 1'b0;
    e = '0;
    sb.push_back(e); #1; pop_compare();
    repeat (3) tick();

    // Start with nobody joined is ignored.
    reset = 1'b1;
    start_btn = 1'b1; tick();
    start_btn = 1'b0; tick();

    player_btn = 4'b0100; e.act = 4'b0100; tick();
    tick();
    player_btn = 4'b0000; tick();
    enter_countdown();
    run_countdown(12);

    // Abort during GAME.
    trigger_reset_all = 1'b1;
    e.scr = 2'b00; e.act = '0; e.ge = 1'b0; tick();
    trigger_reset_all = 1'b0;

    // Join and start together: join lands, start sees the empty pre-join mask.
    player_btn = 4'b1011; start_btn = 1'b1; e.act = 4'b1011; tick();
    player_btn = 4'b0000; start_btn = 1'b0; tick();
    enter_countdown();
    run_countdown(4);
    trigger_reset_all = 1'b1;
    e.scr = 2'b00; e.cd = 3'd0; e.act = '0; tick();
    trigger_reset_all = 1'b0;

    player_btn = 4'b1011; e.act = 4'b1011; tick();
    player_btn = 4'b0000; tick();
    enter_countdown();
    run_countdown(12);

    // Unjoined lane finishing first changes nothing.
    player_finished = 4'b0100; tick();
    player_finished = 4'b1110;
    e.scr = 2'b10; e.ge = 1'b0; e.wid = 2'd1; e.wv = 1'b1; tick();

    player_finished = 4'b0001; player_btn = 4'b0100; start_btn = 1'b1; tick();
    player_finished = 4'b1111; player_btn = 4'b0000; start_btn = 1'b0; tick();
    player_finished = 4'b0000; tick();

    trigger_reset_all = 1'b1;
    e.scr = 2'b00; e.act = '0; e.wv = 1'b0; tick();
    trigger_reset_all = 1'b0; tick();

    player_btn = 4'b1000; e.act = 4'b1000; tick();
    player_btn = 4'b0000; tick();
    enter_countdown();
    run_countdown(12);
    tick();

    // Asynchronous reset between edges.
    #3;
    reset = 1'b0;
    e = '0;
    sb.push_back(e); #1; pop_compare();
    tick();
    reset = 1'b1; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/race_screen_controller.md
Name: race_screen_controller

Overview:
- Top-level game sequencer for the LED racer; sole owner of the 2-bit current_screen bus that the screen, render and end-game logic consume.
- Collects player joins in the menu and runs a start countdown.
- Arbitrates the winner among finishing players, then holds the end screen until trigger_reset_all returns the game to the menu.

Parameters:
- NUM_PLAYERS, 4, number of player lanes/buttons; legal range 1..4.
- COUNTDOWN_START, 3, first countdown digit shown; legal range 1..7.
- COUNTDOWN_STEP_CLK_COUNT, 1, clocks per countdown digit; must be >= 1.
- MIN_PLAYERS, 1, joined players required before start is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- player_btn  in  NUM_PLAYERS  debounced, synchronised player buttons (level).
- start_btn  in  1  debounced, synchronised start button (level).
- player_finished  in  NUM_PLAYERS  level from race logic; bit i high once lane i crosses the finish.
- trigger_reset_all  in  1  one-cycle pulse requesting return to menu.
- current_screen  out  2  00 MENU, 11 COUNTDOWN, 01 GAME, 10 END.
- active_players  out  NUM_PLAYERS  joined-player mask.
- countdown_value  out  3  digit currently displayed; 0 outside COUNTDOWN.
- game_enable  out  1  high only in GAME; gates player movement.
- winner_id  out  2  index of the winning lane.
- winner_valid  out  1  high in END when winner_id is meaningful.

Behaviour:
- All outputs are registered. An input event at edge N is visible on the outputs after edge N.
- Reset (reset=0) forces, asynchronously: current_screen=00, active_players=0, countdown_value=0, game_enable=0, winner_id=0, winner_valid=0. Edge-detect history and step counter are cleared.
- Rising-edge detection is internal for player_btn and start_btn: rise = current level & ~previous level.
- Priority in every state: trigger_reset_all=1 -> next state MENU, active_players=0, winner_valid=0, countdown_value=0. This overrides all other events in the same cycle.
- MENU:
  - A rise on player_btn[i] sets active_players[i]. A bit is never cleared in MENU. Simultaneous rises on several bits all set.
  - A start_btn rise while popcount(active_players) >= MIN_PLAYERS -> COUNTDOWN, countdown_value=COUNTDOWN_START, step counter=0.
  - A join and a start in the same cycle: the join is applied, but the start check uses the pre-join mask.
  - A start rise below MIN_PLAYERS is ignored.
- COUNTDOWN:
  - The step counter increments each clock.
  - When it reaches COUNTDOWN_STEP_CLK_COUNT-1, it wraps to 0 and countdown_value decrements.
  - A decrement from 1 -> enter GAME, countdown_value=0, game_enable=1.
  - Total COUNTDOWN dwell is exactly COUNTDOWN_START*COUNTDOWN_STEP_CLK_COUNT cycles.
  - Buttons are ignored.
- GAME:
  - Compute hit = player_finished & active_players.
  - First cycle with hit != 0 -> END, winner_id = lowest set index of hit, winner_valid=1, game_enable=0.
  - Finish bits of non-joined lanes are always ignored.
- END:
  - Outputs hold; later player_finished changes do not alter winner_id.
  - Only trigger_reset_all leaves END.
- winner_id keeps its last value after leaving END; it is qualified by winner_valid only.
- Encoding 11 is used for COUNTDOWN only; no unreachable state exists.

Decomposition:
- Shared package (race_pkg):
  - screen encodings SCREEN_MENU=2'b00, SCREEN_GAME=2'b01, SCREEN_END=2'b10, SCREEN_COUNTDOWN=2'b11;
  - MAX_PLAYERS=4;
  - PLAYER_ID_W=2.
- One sub-module is natural: btn_rise_detect (width-parameterised registered rising-edge detector, async active-low reset). It is instantiated for player_btn and start_btn.
- Step counter and winner priority encoder stay inline.

Test Plan:
- Reset/join/start: reset low 3 cycles then high, with start_btn pulsed and no joins -> screen stays 00. Then pulse player_btn[2] and later start_btn -> active_players=4'b0100, screen=11 one cycle after the start rise, countdown_value=3.
- Countdown timing with COUNTDOWN_STEP_CLK_COUNT=4 -> countdown_value steps 3,2,1, each held 4 cycles. Screen becomes 01 and game_enable=1 exactly 12 cycles after COUNTDOWN entry.
- Winner arbitration: active_players=4'b1011; drive player_finished=4'b1110 in one cycle -> bit 2 is masked out, hit=4'b1010, winner_id=1, winner_valid=1, screen=10, game_enable=0.
- End hold and release: in END, toggle player_finished and the buttons -> no output change. Pulse trigger_reset_all -> next cycle screen=00, active_players=0, winner_valid=0.
- Abort mid-countdown: trigger_reset_all at countdown_value=2 -> screen=00 and countdown_value=0 next cycle. The same abort applied during GAME clears game_enable.
- Async reset mid-GAME: reset low between clock edges -> outputs return to reset values immediately, without waiting for a clock edge.
